// File: rtl/biriscv_branch_resolve_if.sv
// ----------------------------------------------------------------------------
// biriscv_branch_resolve_if
//
// Bundles the resolved-branch inputs from the two execute pipes and the
// predictor-update outputs that leave the resolve block.
//
//   pN_*        : resolved control-flow instruction from execute pipe N
//                 (pipe 0 is the older of the two)
//   branch_*    : predictor update (mispredict redirect or BHT training)
//   perf_*      : mispredict / dropped-training event counters
//
// Modports:
//   master : execute side / environment (drives pN_*, observes branch_*)
//   slave  : the resolve block itself
// ----------------------------------------------------------------------------
interface biriscv_branch_resolve_if;
  logic        p0_valid_i;
  logic [31:0] p0_pc_i;
  logic [31:0] p0_target_i;
  logic        p0_taken_i;
  logic        p0_pred_taken_i;
  logic [31:0] p0_pred_pc_i;
  logic        p0_is_cond_i;
  logic        p0_is_call_i;
  logic        p0_is_ret_i;
  logic        p0_is_jmp_i;

  logic        p1_valid_i;
  logic [31:0] p1_pc_i;
  logic [31:0] p1_target_i;
  logic        p1_taken_i;
  logic        p1_pred_taken_i;
  logic [31:0] p1_pred_pc_i;
  logic        p1_is_cond_i;
  logic        p1_is_call_i;
  logic        p1_is_ret_i;
  logic        p1_is_jmp_i;

  logic        branch_request_o;
  logic        branch_is_taken_o;
  logic        branch_is_not_taken_o;
  logic [31:0] branch_source_o;
  logic [31:0] branch_pc_o;
  logic        branch_is_call_o;
  logic        branch_is_ret_o;
  logic        branch_is_jmp_o;
  logic [31:0] perf_mispred_o;
  logic [31:0] perf_drop_o;

  modport master (
    output p0_valid_i, p0_pc_i, p0_target_i, p0_taken_i, p0_pred_taken_i,
           p0_pred_pc_i, p0_is_cond_i, p0_is_call_i, p0_is_ret_i, p0_is_jmp_i,
    output p1_valid_i, p1_pc_i, p1_target_i, p1_taken_i, p1_pred_taken_i,
           p1_pred_pc_i, p1_is_cond_i, p1_is_call_i, p1_is_ret_i, p1_is_jmp_i,
    input  branch_request_o, branch_is_taken_o, branch_is_not_taken_o,
           branch_source_o, branch_pc_o, branch_is_call_o, branch_is_ret_o,
           branch_is_jmp_o, perf_mispred_o, perf_drop_o
  );

  modport slave (
    input  p0_valid_i, p0_pc_i, p0_target_i, p0_taken_i, p0_pred_taken_i,
           p0_pred_pc_i, p0_is_cond_i, p0_is_call_i, p0_is_ret_i, p0_is_jmp_i,
    input  p1_valid_i, p1_pc_i, p1_target_i, p1_taken_i, p1_pred_taken_i,
           p1_pred_pc_i, p1_is_cond_i, p1_is_call_i, p1_is_ret_i, p1_is_jmp_i,
    output branch_request_o, branch_is_taken_o, branch_is_not_taken_o,
           branch_source_o, branch_pc_o, branch_is_call_o, branch_is_ret_o,
           branch_is_jmp_o, perf_mispred_o, perf_drop_o
  );
endinterface

// File: rtl/biriscv_branch_resolve.sv
// ----------------------------------------------------------------------------
// biriscv_branch_resolve
//
// Collects resolved control-flow outcomes from both execute pipes, compares
// each against its fetch-time prediction and emits at most one predictor
// update per cycle:
//   - a registered mispredict redirect / BTB-RAS update (request=1), or
//   - a BHT training update for a correctly predicted conditional branch,
//     buffered in a small FIFO and drained in cycles with no mispredict.
//
// Ports:
//   clk_i  : clock
//   rst_n  : asynchronous active-low reset
//   bus    : biriscv_branch_resolve_if.slave (pipe inputs, update outputs,
//            perf counters)
//
// Parameters:
//   FIFO_DEPTH   : training FIFO entries (power of 2, >= 2)
//   FIFO_DEPTH_W : log2(FIFO_DEPTH)
//
// Optional feature macro: BRANCH_RESOLVE_PERF_EN
//   defined   -> saturating mispredict / dropped-training counters
//   undefined -> counters not built, perf outputs tied to zero
// ----------------------------------------------------------------------------
module biriscv_branch_resolve #(
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_DEPTH_W = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  biriscv_branch_resolve_if.slave        bus
);

  localparam int CW = FIFO_DEPTH_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] source;
    logic [31:0] next_pc;
    logic        taken;
  } train_t;

  // --------------------------------------------------------------------------
  // Outcome vs prediction
  // --------------------------------------------------------------------------
  logic [31:0] p0_next_pc;
  logic [31:0] p1_next_pc;
  logic        p0_mispred;
  logic        p1_mispred;
  logic        p0_train;
  logic        p1_train;

  assign p0_next_pc = bus.p0_taken_i ? bus.p0_target_i : bus.p0_pc_i + 32'd4;
  assign p1_next_pc = bus.p1_taken_i ? bus.p1_target_i : bus.p1_pc_i + 32'd4;

  assign p0_mispred = bus.p0_valid_i &
                      ((bus.p0_taken_i != bus.p0_pred_taken_i) |
                       (p0_next_pc != bus.p0_pred_pc_i));
  assign p1_mispred = bus.p1_valid_i &
                      ((bus.p1_taken_i != bus.p1_pred_taken_i) |
                       (p1_next_pc != bus.p1_pred_pc_i));

  assign p0_train = bus.p0_valid_i & bus.p0_is_cond_i;
  assign p1_train = bus.p1_valid_i & bus.p1_is_cond_i;

  // --------------------------------------------------------------------------
  // Training FIFO control
  // --------------------------------------------------------------------------
  train_t                  fifo_q [FIFO_DEPTH];
  logic [FIFO_DEPTH_W-1:0] rd_ptr_q;
  logic [FIFO_DEPTH_W-1:0] wr_ptr_q;
  logic [FIFO_DEPTH_W-1:0] wr_ptr_inc;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           free_slots;

  logic push0_req;
  logic push1_req;
  logic push0;
  logic push1;
  logic pop;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the if/else leaves it unassigned and infers a latch.
  always_comb begin
    push0_req = 1'b0;
    push1_req = 1'b0;
    pop       = 1'b0;
    if (p0_mispred) begin
      // p1 is younger than a redirecting p0: it is on the wrong path.
    end else if (p1_mispred) begin
      push0_req = p0_train;
    end else begin
      push0_req = p0_train;
      push1_req = p1_train;
      pop       = (count_q != '0);
    end
  end

  // The slot freed by this cycle's pop is available to this cycle's pushes.
  assign free_slots = DEPTH_C - count_q + CW'(pop);

  // p0 is older, so when only one slot is free it goes to p0.
  assign push0 = push0_req & (free_slots != '0);
  assign push1 = push1_req & (push0 ? (free_slots >= CW'(2)) : (free_slots != '0));

  assign wr_ptr_inc = wr_ptr_q + FIFO_DEPTH_W'(1);

  // NOTE: the FIFO storage has no reset; the pointers and count define which
  // entries are live, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push0) begin
      fifo_q[wr_ptr_q] <= '{source: bus.p0_pc_i, next_pc: p0_next_pc,
                            taken: bus.p0_taken_i};
    end
    if (push1) begin
      fifo_q[push0 ? wr_ptr_inc : wr_ptr_q] <= '{source: bus.p1_pc_i,
                                                 next_pc: p1_next_pc,
                                                 taken: bus.p1_taken_i};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_W'(pop);
      wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_W'(push0) + FIFO_DEPTH_W'(push1);
      count_q  <= count_q - CW'(pop) + CW'(push0) + CW'(push1);
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  train_t      head;
  logic        request_q;
  logic        taken_q;
  logic        not_taken_q;
  logic [31:0] source_q;
  logic [31:0] pc_q;
  logic        call_q;
  logic        ret_q;
  logic        jmp_q;

  assign head = fifo_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      request_q   <= 1'b0;
      taken_q     <= 1'b0;
      not_taken_q <= 1'b0;
      source_q    <= '0;
      pc_q        <= '0;
      call_q      <= 1'b0;
      ret_q       <= 1'b0;
      jmp_q       <= 1'b0;
    end else begin
      // Strobes are single-cycle; source/pc hold their last value when idle.
      request_q   <= 1'b0;
      taken_q     <= 1'b0;
      not_taken_q <= 1'b0;
      call_q      <= 1'b0;
      ret_q       <= 1'b0;
      jmp_q       <= 1'b0;
      if (p0_mispred) begin
        request_q   <= 1'b1;
        taken_q     <= bus.p0_taken_i;
        not_taken_q <= ~bus.p0_taken_i;
        source_q    <= bus.p0_pc_i;
        pc_q        <= p0_next_pc;
        call_q      <= bus.p0_is_call_i;
        ret_q       <= bus.p0_is_ret_i;
        jmp_q       <= bus.p0_is_jmp_i;
      end else if (p1_mispred) begin
        request_q   <= 1'b1;
        taken_q     <= bus.p1_taken_i;
        not_taken_q <= ~bus.p1_taken_i;
        source_q    <= bus.p1_pc_i;
        pc_q        <= p1_next_pc;
        call_q      <= bus.p1_is_call_i;
        ret_q       <= bus.p1_is_ret_i;
        jmp_q       <= bus.p1_is_jmp_i;
      end else if (pop) begin
        taken_q     <= head.taken;
        not_taken_q <= ~head.taken;
        source_q    <= head.source;
        pc_q        <= head.next_pc;
      end
    end
  end

  assign bus.branch_request_o      = request_q;
  assign bus.branch_is_taken_o     = taken_q;
  assign bus.branch_is_not_taken_o = not_taken_q;
  assign bus.branch_source_o       = source_q;
  assign bus.branch_pc_o           = pc_q;
  assign bus.branch_is_call_o      = call_q;
  assign bus.branch_is_ret_o       = ret_q;
  assign bus.branch_is_jmp_o       = jmp_q;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef BRANCH_RESOLVE_PERF_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [1:0]  drop_cnt;
  logic [31:0] mispred_cnt_q;
  logic [31:0] drop_cnt_q;

  assign drop_cnt = {1'b0, push0_req & ~push0} + {1'b0, push1_req & ~push1};

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mispred_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      if ((p0_mispred | p1_mispred) && (mispred_cnt_q != CNT_MAX)) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
      if (drop_cnt != 2'd0) begin
        drop_cnt_q <= (drop_cnt_q > (CNT_MAX - 32'(drop_cnt))) ? CNT_MAX
                                                               : drop_cnt_q + 32'(drop_cnt);
      end
    end
  end

  assign bus.perf_mispred_o = mispred_cnt_q;
  assign bus.perf_drop_o    = drop_cnt_q;
`else
  assign bus.perf_mispred_o = 32'h0;
  assign bus.perf_drop_o    = 32'h0;
`endif

endmodule

// File: tb/tb_biriscv_branch_resolve.sv
// ----------------------------------------------------------------------------
// tb_biriscv_branch_resolve
//
// Directed scenarios with hand-derived expectations plus a randomized run
// compared cycle by cycle against a queue-based reference model.
// Honours BRANCH_RESOLVE_PERF_EN for the expected counter values.
// ----------------------------------------------------------------------------
module tb_biriscv_branch_resolve;

  localparam int DEPTH = 4;
`ifdef BRANCH_RESOLVE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  biriscv_branch_resolve_if bif ();

  biriscv_branch_resolve #(
    .FIFO_DEPTH   (DEPTH),
    .FIFO_DEPTH_W (2)
  ) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        cond;
    logic        call;
    logic        ret;
    logic        jmp;
  } pipe_t;

  typedef struct packed {
    logic        req;
    logic        tk;
    logic        ntk;
    logic        call;
    logic        ret;
    logic        jmp;
    logic [31:0] src;
    logic [31:0] pc;
  } obs_t;

  int checks = 0;
  int errors = 0;

  // ---------------- stimulus / expectation builders ----------------
  function automatic logic [31:0] next_of(pipe_t p);
    return p.taken ? p.target : p.pc + 32'd4;
  endfunction

  function automatic pipe_t no_pipe();
    pipe_t p = '0;
    return p;
  endfunction

  // Conditional branch with target pc+0x80; prediction right or direction-wrong.
  function automatic pipe_t cond_br(logic [31:0] pc, logic taken, logic correct);
    pipe_t p = '0;
    p.valid      = 1'b1;
    p.pc         = pc;
    p.target     = pc + 32'h80;
    p.taken      = taken;
    p.cond       = 1'b1;
    p.pred_taken = correct ? taken : ~taken;
    p.pred_pc    = p.pred_taken ? p.target : pc + 32'd4;
    return p;
  endfunction

  function automatic pipe_t jump(logic [31:0] pc, logic [31:0] target,
                                 logic [31:0] pred_pc, logic call, logic ret, logic jmp);
    pipe_t p = '0;
    p.valid      = 1'b1;
    p.pc         = pc;
    p.target     = target;
    p.taken      = 1'b1;
    p.pred_taken = 1'b1;
    p.pred_pc    = pred_pc;
    p.call       = call;
    p.ret        = ret;
    p.jmp        = jmp;
    return p;
  endfunction

  function automatic obs_t exp_req(pipe_t p);
    obs_t o;
    o = '{req: 1'b1, tk: p.taken, ntk: ~p.taken, call: p.call, ret: p.ret,
          jmp: p.jmp, src: p.pc, pc: next_of(p)};
    return o;
  endfunction

  function automatic obs_t exp_train(pipe_t p);
    obs_t o;
    o = '{req: 1'b0, tk: p.taken, ntk: ~p.taken, call: 1'b0, ret: 1'b0,
          jmp: 1'b0, src: p.pc, pc: next_of(p)};
    return o;
  endfunction

  function automatic obs_t exp_idle(logic [31:0] src, logic [31:0] pc);
    obs_t o = '0;
    o.src = src;
    o.pc  = pc;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = '{req: bif.branch_request_o, tk: bif.branch_is_taken_o,
          ntk: bif.branch_is_not_taken_o, call: bif.branch_is_call_o,
          ret: bif.branch_is_ret_o, jmp: bif.branch_is_jmp_o,
          src: bif.branch_source_o, pc: bif.branch_pc_o};
    return o;
  endfunction

  task automatic drive(input pipe_t a, input pipe_t b);
    bif.p0_valid_i = a.valid;  bif.p0_pc_i = a.pc;  bif.p0_target_i = a.target;
    bif.p0_taken_i = a.taken;  bif.p0_pred_taken_i = a.pred_taken;
    bif.p0_pred_pc_i = a.pred_pc;  bif.p0_is_cond_i = a.cond;
    bif.p0_is_call_i = a.call; bif.p0_is_ret_i = a.ret; bif.p0_is_jmp_i = a.jmp;
    bif.p1_valid_i = b.valid;  bif.p1_pc_i = b.pc;  bif.p1_target_i = b.target;
    bif.p1_taken_i = b.taken;  bif.p1_pred_taken_i = b.pred_taken;
    bif.p1_pred_pc_i = b.pred_pc;  bif.p1_is_cond_i = b.cond;
    bif.p1_is_call_i = b.call; bif.p1_is_ret_i = b.ret; bif.p1_is_jmp_i = b.jmp;
  endtask

  // One active edge, then settle before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(no_pipe(), no_pipe());
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    drive(no_pipe(), no_pipe());
    @(posedge clk);
    @(posedge clk);
    #1;
    o = observe();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", o, obs_t'('0));
    end
    checks++;
    if (bif.perf_mispred_o !== 32'h0 || bif.perf_drop_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_perf: got %h/%h want 0/0", bif.perf_mispred_o, bif.perf_drop_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_p0_mispredict();
    obs_t o;
    obs_t e;
    do_reset();
    drive(cond_br(32'h100, 1'b1, 1'b0), no_pipe());
    step();
    o = observe();
    e = '{req: 1'b1, tk: 1'b1, ntk: 1'b0, call: 1'b0, ret: 1'b0, jmp: 1'b0,
          src: 32'h100, pc: 32'h180};
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL p0_mispredict: got %h want %h", o, e);
    end
    checks++;
    if (bif.perf_mispred_o !== (PERF ? 32'd1 : 32'd0)) begin
      errors++;
      $display("FAIL p0_mispredict_perf: got %0d want %0d", bif.perf_mispred_o, PERF ? 1 : 0);
    end
    drive(no_pipe(), no_pipe());
    step();
    o = observe();
    checks++;
    if (o !== exp_idle(32'h100, 32'h180)) begin
      errors++;
      $display("FAIL p0_mispredict_one_cycle: got %h want %h", o, exp_idle(32'h100, 32'h180));
    end
  endtask

  task automatic test_dual_mispredict();
    obs_t  o;
    pipe_t a;
    a = cond_br(32'h140, 1'b0, 1'b0);
    do_reset();
    drive(a, cond_br(32'h144, 1'b1, 1'b0));
    step();
    o = observe();
    checks++;
    if (o !== exp_req(a)) begin
      errors++;
      $display("FAIL dual_mispredict_p0: got %h want %h", o, exp_req(a));
    end
    drive(no_pipe(), no_pipe());
    for (int i = 0; i < 2; i++) begin
      step();
      o = observe();
      checks++;
      if (o !== exp_idle(32'h140, 32'h144)) begin
        errors++;
        $display("FAIL dual_mispredict_no_push[%0d]: got %h want %h", i, o,
                 exp_idle(32'h140, 32'h144));
      end
    end
    checks++;
    if (bif.perf_mispred_o !== (PERF ? 32'd1 : 32'd0)) begin
      errors++;
      $display("FAIL dual_mispredict_perf: got %0d want %0d", bif.perf_mispred_o, PERF ? 1 : 0);
    end
  endtask

  task automatic test_train_pair();
    obs_t o;
    obs_t e [4];
    e[0] = exp_idle(32'h0, 32'h0);
    e[1] = '{req: 1'b0, tk: 1'b0, ntk: 1'b1, call: 1'b0, ret: 1'b0, jmp: 1'b0,
             src: 32'h200, pc: 32'h204};
    e[2] = '{req: 1'b0, tk: 1'b1, ntk: 1'b0, call: 1'b0, ret: 1'b0, jmp: 1'b0,
             src: 32'h204, pc: 32'h284};
    e[3] = exp_idle(32'h204, 32'h284);
    do_reset();
    drive(cond_br(32'h200, 1'b0, 1'b1), cond_br(32'h204, 1'b1, 1'b1));
    for (int i = 0; i < 4; i++) begin
      step();
      drive(no_pipe(), no_pipe());
      o = observe();
      checks++;
      if (o !== e[i]) begin
        errors++;
        $display("FAIL train_pair[%0d]: got %h want %h", i, o, e[i]);
      end
    end
  endtask

  task automatic test_ret_mispredict();
    obs_t o;
    obs_t e [3];
    e[0] = '{req: 1'b1, tk: 1'b1, ntk: 1'b0, call: 1'b0, ret: 1'b1, jmp: 1'b0,
             src: 32'h300, pc: 32'h400};
    e[1] = '{req: 1'b0, tk: 1'b1, ntk: 1'b0, call: 1'b0, ret: 1'b0, jmp: 1'b0,
             src: 32'h2F0, pc: 32'h370};
    e[2] = exp_idle(32'h2F0, 32'h370);
    do_reset();
    drive(cond_br(32'h2F0, 1'b1, 1'b1),
          jump(32'h300, 32'h400, 32'h500, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      step();
      drive(no_pipe(), no_pipe());
      o = observe();
      checks++;
      if (o !== e[i]) begin
        errors++;
        $display("FAIL ret_mispredict[%0d]: got %h want %h", i, o, e[i]);
      end
    end
  endtask

  task automatic test_fifo_overflow();
    pipe_t a [5];
    pipe_t b [5];
    obs_t  e [10];
    obs_t  o;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] pc;
      pc   = 32'h1000 + 32'(i * 8);
      a[i] = cond_br(pc, pc[3], 1'b1);
      b[i] = cond_br(pc + 32'd4, ~pc[3], 1'b1);
    end
    // Cycle 3: p1 jump mispredicts while the FIFO is full, so p0 is dropped.
    b[3] = jump(32'h101C, 32'h2000, 32'h3000, 1'b0, 1'b0, 1'b1);
    e[0] = exp_idle(32'h0, 32'h0);
    e[1] = exp_train(a[0]);
    e[2] = exp_train(b[0]);
    e[3] = exp_req(b[3]);
    e[4] = exp_train(a[1]);
    e[5] = exp_train(b[1]);
    e[6] = exp_train(a[2]);
    e[7] = exp_train(b[2]);
    e[8] = exp_train(a[4]);
    e[9] = exp_idle(a[4].pc, next_of(a[4]));
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 5) drive(a[i], b[i]);
      else       drive(no_pipe(), no_pipe());
      step();
      o = observe();
      checks++;
      if (o !== e[i]) begin
        errors++;
        $display("FAIL fifo_overflow[%0d]: got %h want %h", i, o, e[i]);
      end
    end
    checks++;
    if (bif.perf_drop_o !== (PERF ? 32'd2 : 32'd0)) begin
      errors++;
      $display("FAIL fifo_overflow_drop: got %0d want %0d", bif.perf_drop_o, PERF ? 2 : 0);
    end
    checks++;
    if (bif.perf_mispred_o !== (PERF ? 32'd1 : 32'd0)) begin
      errors++;
      $display("FAIL fifo_overflow_mispred: got %0d want %0d", bif.perf_mispred_o, PERF ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid_drain();
    obs_t  o;
    pipe_t b0;
    b0 = cond_br(32'h504, 1'b1, 1'b1);
    do_reset();
    drive(cond_br(32'h500, 1'b0, 1'b1), b0);
    step();
    drive(cond_br(32'h508, 1'b1, 1'b1), cond_br(32'h50C, 1'b0, 1'b1));
    step();
    drive(no_pipe(), no_pipe());
    step();
    o = observe();
    checks++;
    if (o !== exp_train(b0)) begin
      errors++;
      $display("FAIL mid_drain_before_reset: got %h want %h", o, exp_train(b0));
    end
    #2;
    rst_n = 1'b0;
    #1;
    o = observe();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL mid_drain_async_reset: got %h want %h", o, obs_t'('0));
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      o = observe();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL mid_drain_after_release[%0d]: got %h want %h", i, o, obs_t'('0));
      end
    end
  endtask

  // ---------------- randomized run vs reference model ----------------
  obs_t        m_out;
  obs_t        m_q [$];
  int unsigned m_mispred;
  int unsigned m_drop;

  function automatic logic is_mis(pipe_t p);
    return p.valid && ((p.taken != p.pred_taken) || (next_of(p) != p.pred_pc));
  endfunction

  function automatic void m_push(pipe_t p);
    if (!(p.valid && p.cond)) return;
    if (m_q.size() < DEPTH) m_q.push_back(exp_train(p));
    else                    m_drop++;
  endfunction

  function automatic void model_step(pipe_t a, pipe_t b);
    m_out.req  = 1'b0;  m_out.tk  = 1'b0;  m_out.ntk = 1'b0;
    m_out.call = 1'b0;  m_out.ret = 1'b0;  m_out.jmp = 1'b0;
    if (is_mis(a)) begin
      m_out = exp_req(a);
      m_mispred++;
    end else if (is_mis(b)) begin
      m_push(a);
      m_out = exp_req(b);
      m_mispred++;
    end else begin
      if (m_q.size() > 0) m_out = m_q.pop_front();
      m_push(a);
      m_push(b);
    end
  endfunction

  function automatic pipe_t rand_pipe();
    pipe_t       p;
    logic [31:0] pc;
    int          kind;
    kind = $urandom_range(0, 9);
    pc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
    if (kind < 6) begin
      p = cond_br(pc, 1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) p.pred_pc = p.pred_pc ^ 32'h10;
    end else begin
      logic [31:0] tgt;
      tgt = $urandom() & 32'hFFFF_FFFC;
      p = jump(pc, tgt, ($urandom_range(0, 3) != 0) ? tgt : tgt ^ 32'h40,
               kind == 6, kind == 7, kind >= 8);
    end
    p.valid = ($urandom_range(0, 4) != 0);
    return p;
  endfunction

  task automatic test_random();
    pipe_t a;
    pipe_t b;
    obs_t  o;
    do_reset();
    m_out     = '0;
    m_q       = {};
    m_mispred = 0;
    m_drop    = 0;
    for (int c = 0; c < 500; c++) begin
      if (c % 50 >= 44) begin
        a = no_pipe();
        b = no_pipe();
      end else begin
        a = rand_pipe();
        b = rand_pipe();
      end
      drive(a, b);
      model_step(a, b);
      step();
      o = observe();
      checks++;
      if (o !== m_out) begin
        errors++;
        $display("FAIL random_out[%0d]: got %h want %h", c, o, m_out);
      end
      checks++;
      if (bif.perf_mispred_o !== (PERF ? 32'(m_mispred) : 32'd0) ||
          bif.perf_drop_o !== (PERF ? 32'(m_drop) : 32'd0)) begin
        errors++;
        $display("FAIL random_perf[%0d]: got %0d/%0d want %0d/%0d", c,
                 bif.perf_mispred_o, bif.perf_drop_o,
                 PERF ? m_mispred : 0, PERF ? m_drop : 0);
      end
    end
    drive(no_pipe(), no_pipe());
  endtask

  initial begin
    drive(no_pipe(), no_pipe());
    test_reset();
    test_p0_mispredict();
    test_dual_mispredict();
    test_train_pair();
    test_ret_mispredict();
    test_fifo_overflow();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/biriscv_branch_resolve.md
# biriscv_branch_resolve

Producer side of the branch-predictor update interface. Sits between the two execute pipes and the next-PC predictor, collects resolved control-flow outcomes from both issue slots and compares each against its prediction. Emits at most one predictor update per cycle: a registered mispredict redirect/BTB-RAS update, or a queued BHT training update for a correctly predicted conditional branch.

## Interface
- FIFO_DEPTH, 4: training FIFO entries (power of 2, ≥2)
- FIFO_DEPTH_W, 2: log2(FIFO_DEPTH)
- clk_i  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pN_valid_i (N=0,1)  in  1  pipe N resolved a control-flow instruction; pipe 0 is older
- pN_pc_i  in  32  source PC
- pN_target_i  in  32  computed target
- pN_taken_i  in  1  actual direction (1 for jal/jalr)
- pN_pred_taken_i  in  1  fetch-time predicted direction
- pN_pred_pc_i  in  32  fetch-time predicted next PC
- pN_is_cond_i / pN_is_call_i / pN_is_ret_i / pN_is_jmp_i  in  1 each  type flags
- branch_request_o  out  1  mispredict redirect + BTB/RAS update
- branch_is_taken_o / branch_is_not_taken_o  out  1 each  direction training
- branch_source_o  out  32  source PC
- branch_pc_o  out  32  correct next PC
- branch_is_call_o / branch_is_ret_o / branch_is_jmp_o  out  1 each  type flags
- perf_mispred_o  out  32  mispredict count
- perf_drop_o  out  32  dropped training updates

## Operation
- Correct next PC: taken ? target : pc+4 (32-bit wrap).
- Mispredict(N) = valid & (taken != pred_taken | correct next PC != pred_pc).
- Per sampled cycle, in priority order:
  - p0 mispredict: load output register with p0 as request; discard all p1 input.
  - else p1 mispredict: enqueue p0 training if p0 valid & is_cond; load output with p1 as request.
  - else: enqueue p0 then p1 training (each only if valid & is_cond); output loads popped FIFO head if non-empty, else idle.
- Correctly predicted non-conditional instructions produce no update.
- Request output: request=1, taken=actual, not_taken=~actual, flags from instruction.
- Training output: request=0, taken/not_taken from entry, call/ret/jmp=0.
- Idle output: all strobes 0; data fields hold last value.
- FIFO: up to 2 pushes/cycle, 1 pop/cycle; pop precedes push for space calculation. Push with no free slot is dropped (p1 dropped before p0), perf_drop_o increments by dropped count. Pointers wrap modulo FIFO_DEPTH.
- Pending training entries are not flushed by a mispredict; they drain in later idle cycles.
- Core deasserts pN_valid_i for wrong-path instructions; block performs no squash of its own.

## Timing
- Inputs sampled at edge N; mispredict update visible cycle N+1 for exactly one cycle.
- Training update: earliest visible cycle N+2 (enqueue N, pop N+1); one per cycle thereafter.
- A mispredict cycle stalls FIFO pop for that cycle only.
- Reset: all outputs 0, FIFO empty, pointers 0, counters 0. Reset mid-drain discards FIFO contents.

## Configuration
- BRANCH_RESOLVE_PERF_EN defined: perf_mispred_o increments once per branch_request_o pulse, perf_drop_o per dropped entry; both saturate at 32'hFFFFFFFF.
- Undefined: counter registers not built; perf_mispred_o and perf_drop_o tied to 32'h0.

## Test plan
- p0 cond pc=0x100, taken=1, target=0x180, pred_taken=0 -> next cycle request=1, taken=1, source=0x100, branch_pc=0x180; perf_mispred_o=1.
- p0 and p1 both mispredict same cycle -> single request for p0; p1 ignored; no FIFO push.
- p0 cond 0x200 correct not-taken, p1 cond 0x204 correct taken -> two training updates in cycles N+2, N+3: not_taken source=0x200, then taken source=0x204, request=0.
- p1 jalr ret pc=0x300 target=0x400, pred_pc=0x500 -> request=1, is_ret=1, branch_pc=0x400; p0 correct cond same cycle queued and emitted afterward.
- Fill FIFO (depth 4) with correct cond pairs while mispredicts block pops -> excess dropped, perf_drop_o counts exactly; FIFO order preserved on drain.
- Assert rst_n low mid-drain -> all outputs 0 immediately, no training updates emitted after release.
